// File: rtl/pc_redirect_sequencer.sv
// IF-stage program counter with EX-stage redirect handling. A redirect that
// arrives during a stall is held and applied when the stall releases.
module pc_redirect_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCWrite,
  input  logic             EXJumpTaken,
  input  logic [31:0]      EXJumpPC,
  input  logic             EXBranchTaken,
  input  logic [31:0]      EXBranchPC,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             RedirectPending,
  output logic             AlignErr,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] pending_q, pending_next;
  logic        req;
  logic [31:0] sel;
  logic [31:0] tgt;

  assign req = EXJumpTaken | EXBranchTaken;
  // Jump wins over branch when both resolve in the same cycle.
  assign sel = EXJumpTaken ? EXJumpPC : EXBranchPC;
  assign tgt = {sel[31:2], 2'b00};

  assign PC              = pc_q;
  assign PCPlus4         = pc_q + 32'd4;
  assign RedirectPending = (state == HOLD);
  // Flushes are gated by rst_n so nothing is squashed while in reset.
  assign IDEXFlush       = rst_n & req;
  assign IFIDFlush       = rst_n & (req | (state == HOLD));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_next   = state;
    pc_next      = pc_q;
    pending_next = pending_q;
    unique case (state)
      RUN: begin
        if (req) begin
          if (PCWrite) begin
            pc_next = tgt;
          end else begin
            pending_next = tgt;
            state_next   = HOLD;
          end
        end else if (PCWrite) begin
          pc_next = PCPlus4;
        end
      end
      HOLD: begin
        if (req) begin
          pending_next = tgt;
          if (PCWrite) begin
            pc_next    = tgt;
            state_next = RUN;
          end
        end else if (PCWrite) begin
          pc_next    = pending_q;
          state_next = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      pending_q     <= 32'd0;
      AlignErr      <= 1'b0;
      RedirectCount <= '0;
    end else begin
      state     <= state_next;
      pc_q      <= pc_next;
      pending_q <= pending_next;
      AlignErr  <= req & (sel[1:0] != 2'b00);
      if (req && (RedirectCount != CNT_MAX)) begin
        RedirectCount <= RedirectCount + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
- Owns the IF-stage program counter and consumes EX-stage control-transfer targets (jump, jump-register, taken branch).
- Applies the redirect to the PC and generates the squash signals for IF/ID and ID/EX.
- Holds a redirect that arrives while the PC is stalled, and applies it once the stall is released.
- Keeps a saturating count of applied redirects for performance debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- PCWrite  in  1  1 = PC may advance; 0 = hazard stall, PC holds.
- EXJumpTaken  in  1  EX-stage jump or jump-register is resolved this cycle.
- EXJumpPC  in  32  target for EXJumpTaken.
- EXBranchTaken  in  1  EX-stage branch is resolved taken this cycle.
- EXBranchPC  in  32  target for EXBranchTaken.
- PC  out  32  current fetch address.
- PCPlus4  out  32  PC + 4 (combinational, wraps modulo 2^32).
- IFIDFlush  out  1  squash the IF/ID register at the next edge.
- IDEXFlush  out  1  squash the ID/EX register at the next edge.
- RedirectPending  out  1  a held redirect is waiting for PCWrite.
- AlignErr  out  1  one-cycle pulse: the accepted target had nonzero bits [1:0].
- RedirectCount  out  CNT_W  number of redirects accepted, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=RUN, pending target=0, RedirectCount=0, AlignErr=0.
  - All flushes 0 while rst_n is low.
- Redirect request: req = EXJumpTaken | EXBranchTaken.
  - Target selection: EXJumpPC if EXJumpTaken, else EXBranchPC. Jump wins if both are asserted.
  - Target alignment: tgt = {sel[31:2], 2'b00}.
  - AlignErr is registered: high for the one cycle after acceptance if sel[1:0] != 0.
- FSM states: RUN and HOLD.
- RUN:
  - req & PCWrite: PC <= tgt at the next edge; stay in RUN.
  - req & !PCWrite: pending <= tgt; go to HOLD; PC holds.
  - !req & PCWrite: PC <= PC+4.
  - !req & !PCWrite: PC holds.
- HOLD:
  - req (any PCWrite): pending <= new tgt. The newest redirect overwrites the held one.
    - If PCWrite=1 at the same time: PC <= new tgt and go to RUN. The held target is discarded.
  - !req & PCWrite: PC <= pending; go to RUN.
  - !req & !PCWrite: stay in HOLD; PC holds.
- Flushes (combinational):
  - IDEXFlush = req.
  - IFIDFlush = req | (state==HOLD).
  - Every cycle in HOLD squashes IF/ID, because the fetched instruction is on the wrong path.
- RedirectPending = (state==HOLD).
- RedirectCount:
  - Increments by 1 on each cycle where req=1. An overwrite in HOLD counts as a new redirect.
  - Holds at 2^CNT_W-1 once reached; no wrap.
- Latency:
  - Request in cycle N with PCWrite=1: PC = tgt in cycle N+1.
  - From HOLD: PC = pending in the cycle after PCWrite returns to 1.
- PC arithmetic: PC+4 at 32'hFFFF_FFFC gives 32'h0000_0000.
- Reset mid-HOLD: the pending target is dropped and PC=RESET_PC. No redirect is applied after reset deasserts.

Test Plan:
- Reset then 3 cycles with PCWrite=1, no req -> PC sequence 0x3000, 0x3004, 0x3008, 0x300C; RedirectCount=0; flushes 0.
- At PC=0x3008: EXJumpTaken=1, EXJumpPC=0x0040_0100, PCWrite=1 -> IFIDFlush=IDEXFlush=1 that cycle; next PC=0x0040_0100; RedirectCount=1.
- Simultaneous EXJumpTaken (0x500) and EXBranchTaken (0x600) -> next PC=0x500.
- PCWrite=0 with EXBranchTaken, EXBranchPC=0x3200:
  - RedirectPending=1; PC unchanged for 2 stall cycles; IFIDFlush=1 each cycle.
  - PCWrite=1 -> next PC=0x3200 and RedirectPending=0.
- In HOLD (pending 0x3200), new EXJumpPC=0x4000 while PCWrite=0 -> pending overwritten; on release PC=0x4000; RedirectCount +2 total.
- Misaligned target plus edge cases:
  - EXJumpPC=0x1003 -> PC=0x1000; AlignErr pulses once.
  - PC=0xFFFF_FFFC with PCWrite=1 -> next PC=0x0.
  - rst_n=0 asserted during HOLD -> PC=0x3000 immediately, RedirectPending=0.
